// File: rtl/wishbone_b4_pipe_slave_mem.sv
// wishbone_b4_pipe_slave_mem
//
// Wishbone B4 pipelined-mode slave backed by an internal byte-lane RAM.
// Each request accepted while the bus is not stalled gets exactly one
// termination (ack, err or rty). That termination appears a fixed LATENCY
// cycles after acceptance, and responses come back in request order.
//
// Ports:
//   clk        bus clock, all logic on the rising edge
//   rst_i      asynchronous active-high reset
//   cyc_i      bus cycle in progress; dropping it cancels in-flight responses
//   stb_i      request strobe
//   we_i       1 = write, 0 = read
//   adr_i      byte address; the word index is adr_i >> log2(DAT_W/8)
//   sel_i      byte-lane enables for writes
//   dat_i      write data
//   tga_i      address tag, returned on tgd_o with the response
//   rty_req_i  forces the request to terminate with rty_o
//   stall_o    high while the outstanding-request limit is reached
//   ack_o      normal termination pulse
//   err_o      error termination pulse (word index beyond the RAM)
//   rty_o      retry termination pulse
//   dat_o      read data with ack_o on reads, otherwise 0
//   tgd_o      tag of the request being answered, otherwise 0

module wishbone_b4_pipe_slave_mem #(
    parameter int DAT_W     = 64,
    parameter int ADR_W     = 32,
    parameter int TAG_W     = 1,
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 2,
    parameter int MAX_OUT   = 4
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               cyc_i,
    input  logic               stb_i,
    input  logic               we_i,
    input  logic [ADR_W-1:0]   adr_i,
    input  logic [DAT_W/8-1:0] sel_i,
    input  logic [DAT_W-1:0]   dat_i,
    input  logic [TAG_W-1:0]   tga_i,
    input  logic               rty_req_i,
    output logic               stall_o,
    output logic               ack_o,
    output logic               err_o,
    output logic               rty_o,
    output logic [DAT_W-1:0]   dat_o,
    output logic [TAG_W-1:0]   tgd_o
);

    localparam int SEL_W   = DAT_W / 8;
    localparam int LANE_SH = (SEL_W > 1) ? $clog2(SEL_W) : 0;
    localparam int IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    localparam logic [ADR_W-1:0] MEM_LIMIT = ADR_W'(MEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        RESP_ACK = 2'd0,
        RESP_ERR = 2'd1,
        RESP_RTY = 2'd2
    } resp_e;

    logic [DAT_W-1:0] r_mem [MEM_WORDS];

    logic             r_vld [LATENCY];
    resp_e            r_cls [LATENCY];
    logic [DAT_W-1:0] r_dat [LATENCY];
    logic [TAG_W-1:0] r_tag [LATENCY];

    logic [CNT_W-1:0] r_out;

    logic             w_accept;
    logic             w_resp;
    logic [ADR_W-1:0] w_word;
    logic [IDX_W-1:0] w_idx;
    logic             w_oob;
    resp_e            w_cls;
    logic [DAT_W-1:0] w_rdata;

    // Stall comes straight from the registered counter, so a response
    // retiring in this cycle only frees a slot from the next cycle on.
    assign stall_o  = (r_out == CNT_MAX);
    assign w_accept = cyc_i & stb_i & ~stall_o & ~rst_i;

    assign w_word = adr_i >> LANE_SH;
    assign w_idx  = w_word[IDX_W-1:0];
    assign w_oob  = (w_word >= MEM_LIMIT);

    // A forced retry wins over an out-of-range error.
    always_comb begin
        w_cls = RESP_ACK;
        if (rty_req_i) begin
            w_cls = RESP_RTY;
        end else if (w_oob) begin
            w_cls = RESP_ERR;
        end
    end

    // Read data is sampled at acceptance. Any earlier write is therefore already in the array.
    assign w_rdata = (w_accept && !we_i && w_cls == RESP_ACK) ? r_mem[w_idx] : '0;

    // RAM contents deliberately survive reset. Only ack-class writes land.
    always_ff @(posedge clk) begin
        if (w_accept && we_i && w_cls == RESP_ACK) begin
            for (int k = 0; k < SEL_W; k++) begin
                if (sel_i[k]) begin
                    r_mem[w_idx][8*k +: 8] <= dat_i[8*k +: 8];
                end
            end
        end
    end

    // Fixed-length response delay line. Dropping cyc_i flushes it so that
    // no stale termination can leak into a later bus cycle.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_vld[i] <= 1'b0;
                r_cls[i] <= RESP_ACK;
                r_dat[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (!cyc_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_vld[i] <= 1'b0;
                r_cls[i] <= RESP_ACK;
                r_dat[i] <= '0;
                r_tag[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_accept;
            r_cls[0] <= w_accept ? w_cls : RESP_ACK;
            r_dat[0] <= w_rdata;
            r_tag[0] <= w_accept ? tga_i : '0;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_cls[i] <= r_cls[i-1];
                r_dat[i] <= r_dat[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Terminations are gated by cyc_i, so nothing is signalled while the master has
    // abandoned the cycle, even before the flush edge.
    assign w_resp = r_vld[LATENCY-1] & cyc_i;

    // Outstanding count: accepted but not yet answered.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_out <= '0;
        end else if (!cyc_i) begin
            r_out <= '0;
        end else if (w_accept && !w_resp) begin
            r_out <= r_out + CNT_ONE;
        end else if (!w_accept && w_resp) begin
            r_out <= r_out - CNT_ONE;
        end
    end

    assign ack_o = w_resp & (r_cls[LATENCY-1] == RESP_ACK);
    assign err_o = w_resp & (r_cls[LATENCY-1] == RESP_ERR);
    assign rty_o = w_resp & (r_cls[LATENCY-1] == RESP_RTY);
    assign dat_o = w_resp ? r_dat[LATENCY-1] : '0;
    assign tgd_o = w_resp ? r_tag[LATENCY-1] : '0;

endmodule

// File: tb/tb_wishbone_b4_pipe_slave_mem.sv
// tb_wishbone_b4_pipe_slave_mem
//
// Drives directed and random Wishbone pipelined traffic into the slave.
// A byte-array memory model predicts each accepted request's termination,
// data, tag and due cycle. Those predictions are queued, and a negedge monitor
// compares them against whatever the slave presents.

module tb_wishbone_b4_pipe_slave_mem;

    localparam int DAT_W     = 64;
    localparam int ADR_W     = 32;
    localparam int TAG_W     = 4;
    localparam int MEM_WORDS = 32;
    localparam int LATENCY   = 4;
    localparam int MAX_OUT   = 4;
    localparam int SEL_W     = DAT_W / 8;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               cyc_i = 1'b0;
    logic               stb_i = 1'b0;
    logic               we_i = 1'b0;
    logic [ADR_W-1:0]   adr_i = '0;
    logic [SEL_W-1:0]   sel_i = '0;
    logic [DAT_W-1:0]   dat_i = '0;
    logic [TAG_W-1:0]   tga_i = '0;
    logic               rty_req_i = 1'b0;
    logic               stall_o;
    logic               ack_o;
    logic               err_o;
    logic               rty_o;
    logic [DAT_W-1:0]   dat_o;
    logic [TAG_W-1:0]   tgd_o;

    wishbone_b4_pipe_slave_mem #(
        .DAT_W(DAT_W), .ADR_W(ADR_W), .TAG_W(TAG_W),
        .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i), .tga_i(tga_i),
        .rty_req_i(rty_req_i), .stall_o(stall_o), .ack_o(ack_o), .err_o(err_o),
        .rty_o(rty_o), .dat_o(dat_o), .tgd_o(tgd_o)
    );

    always #5 clk = ~clk;

    // Expected response: {ack,err,rty} one-hot, read data, tag, and the
    // edge number after which it must be visible.
    typedef struct {
        int               due;
        logic [2:0]       resp;
        logic [DAT_W-1:0] dat;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] memModel [MEM_WORDS*SEL_W];
    int         edgeN = 0;
    int         total = 0;
    int         bad = 0;
    bit         stallExp = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, edgeN, act, expv);
        end
    endtask

    // Reference behaviour of one accepted request, straight from the bus rules.
    task automatic modelAccept();
        exp_t e;
        logic [ADR_W-1:0] word;
        int base;
        word  = adr_i / SEL_W;
        e.due = edgeN + LATENCY - 1;
        e.tag = tga_i;
        e.dat = '0;
        if (rty_req_i) begin
            e.resp = 3'b001;
        end else if (word >= ADR_W'(MEM_WORDS)) begin
            e.resp = 3'b010;
        end else begin
            e.resp = 3'b100;
            base = int'(word) * SEL_W;
            for (int k = 0; k < SEL_W; k++) begin
                if (we_i) begin
                    if (sel_i[k]) memModel[base + k] = dat_i[8*k +: 8];
                end else begin
                    e.dat[8*k +: 8] = memModel[base + k];
                end
            end
        end
        sb.push_back(e);
    endtask

    // One clock: decide acceptance from the model's view of stall, then
    // check the slave's stall flag against the model after the edge.
    task automatic tick(output bit acc);
        acc = cyc_i && stb_i && !stallExp && !rst_i;
        @(posedge clk);
        edgeN++;
        if (acc) modelAccept();
        stallExp = (sb.size() == MAX_OUT);
        #1;
        if (!rst_i) checkOutput("stall", {63'd0, stall_o}, {63'd0, stallExp});
    endtask

    task automatic applyStimulus(input bit c, input bit s, input bit w, input logic [ADR_W-1:0] a,
                                 input logic [SEL_W-1:0] sl, input logic [DAT_W-1:0] d,
                                 input logic [TAG_W-1:0] tg, input bit rty, output bit acc);
        cyc_i = c; stb_i = s; we_i = w; adr_i = a; sel_i = sl;
        dat_i = d; tga_i = tg; rty_req_i = rty;
        // Abandoning the cycle cancels every response still owed.
        if (!c) sb.delete();
        tick(acc);
    endtask

    task automatic request(input bit w, input logic [ADR_W-1:0] a, input logic [SEL_W-1:0] sl,
                           input logic [DAT_W-1:0] d, input logic [TAG_W-1:0] tg, input bit rty);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            applyStimulus(1'b1, 1'b1, w, a, sl, d, tg, rty, acc);
            tries++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: request at 0x%0h not accepted after %0d cycles", a, tries);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, acc);
        end
    endtask

    // Monitor: compares what the slave presents with the queued expectation that is due now.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0 && sb[0].due == edgeN) begin
            e = sb.pop_front();
            checkOutput("resp_kind", {61'd0, ack_o, err_o, rty_o}, {61'd0, e.resp});
            checkOutput("resp_dat", dat_o, e.dat);
            checkOutput("resp_tag", {60'd0, tgd_o}, {60'd0, e.tag});
        end else begin
            checkOutput("no_resp", {61'd0, ack_o, err_o, rty_o}, 64'd0);
            checkOutput("idle_dat", dat_o, 64'd0);
            checkOutput("idle_tag", {60'd0, tgd_o}, 64'd0);
        end
    end

    initial begin
        bit acc;
        logic [ADR_W-1:0] a;

        // Reset state.
        tick(acc);
        tick(acc);
        checkOutput("rst_stall", {63'd0, stall_o}, 64'd0);
        checkOutput("rst_term", {61'd0, ack_o, err_o, rty_o}, 64'd0);
        checkOutput("rst_dat", dat_o, 64'd0);
        rst_i = 1'b0;
        idle(2);

        // Give every word a known value.
        for (int w = 0; w < MEM_WORDS; w++) begin
            request(1'b1, ADR_W'(w * SEL_W), 8'hFF, {$urandom, $urandom}, TAG_W'(w), 1'b0);
        end
        idle(LATENCY + 1);

        // Full write then read of the same word.
        request(1'b1, 32'h10, 8'hFF, 64'h1122334455667788, 4'h5, 1'b0);
        request(1'b0, 32'h10, 8'h00, '0, 4'hA, 1'b0);
        idle(LATENCY + 1);

        // Partial-lane write merges with existing bytes.
        request(1'b1, 32'h0, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 4'h1, 1'b0);
        request(1'b0, 32'h3, 8'h00, '0, 4'h2, 1'b0);
        idle(LATENCY + 1);

        // Six back-to-back reads run into the outstanding limit.
        for (int i = 0; i < 6; i++) request(1'b0, ADR_W'(i * SEL_W), 8'h00, '0, TAG_W'(i + 3), 1'b0);
        idle(LATENCY + 2);

        // First address past the RAM, then a retried write that must not land.
        request(1'b0, ADR_W'(MEM_WORDS * SEL_W), 8'h00, '0, 4'h7, 1'b0);
        request(1'b1, 32'h10, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, 4'h8, 1'b1);
        request(1'b0, 32'h10, 8'h00, '0, 4'h9, 1'b0);
        idle(LATENCY + 1);

        // Abandon a cycle with three reads in flight, then resume.
        for (int i = 0; i < 3; i++) request(1'b0, ADR_W'(i * SEL_W), 8'h00, '0, TAG_W'(i), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, acc);
        idle(1);
        checkOutput("post_drop_stall", {63'd0, stall_o}, 64'd0);
        request(1'b0, 32'h10, 8'h00, '0, 4'hC, 1'b0);
        idle(LATENCY + 1);

        // Reset while the first of two reads is being answered.
        request(1'b0, 32'h8, 8'h00, '0, 4'hD, 1'b0);
        request(1'b0, 32'h18, 8'h00, '0, 4'hE, 1'b0);
        idle(LATENCY - 2);
        stb_i = 1'b0;
        rst_i = 1'b1;
        sb.delete();
        stallExp = 1'b0;
        #1;
        checkOutput("async_rst_term", {61'd0, ack_o, err_o, rty_o}, 64'd0);
        checkOutput("async_rst_dat", dat_o, 64'd0);
        checkOutput("async_rst_tag", {60'd0, tgd_o}, 64'd0);
        tick(acc);
        tick(acc);
        rst_i = 1'b0;
        idle(LATENCY + 2);

        // Random traffic with occasional cycle drops and retries.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) a = $urandom;
            else a = $urandom_range(0, (MEM_WORDS + 4) * SEL_W - 1);
            applyStimulus($urandom_range(0, 19) != 0, 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), a, 8'($urandom), {$urandom, $urandom},
                          TAG_W'($urandom), $urandom_range(0, 7) == 0, acc);
        end
        idle(LATENCY + 2);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
